// File: rtl/rand_ice_status.sv
// LED status controller: heartbeat chaser on the red LEDs, sticky alarm flash,
// and a green LED showing key-loaded or pulse-stretched entropy activity.
module rand_ice_status #(
  parameter int NUM_LEDS       = 4,
  parameter int COUNTER_WIDTH  = 22,
  parameter int CHASE_BIT      = 19,
  parameter int ALARM_BIT      = 17,
  parameter int STRETCH_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                alarm,
  input  logic                alarm_clear,
  input  logic                activity,
  input  logic                key_loaded,
  output logic [NUM_LEDS-1:0] led,
  output logic                gled,
  output logic                alarm_latched
);

  localparam int SW = $clog2(STRETCH_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, ALARM} state_e;

  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_LEDS-1:0]      chase_q, chase_d;
  logic [SW-1:0]            stretch_q, stretch_d;
  logic                     key_q, key_d;
  logic [NUM_LEDS-1:0]      led_q, led_d;
  logic                     gled_q, gled_d;
  logic                     alarm_latched_q, alarm_latched_d;
  logic                     enter_run;

  // Next state: alarm overrides everything, ALARM only left via a clean clear.
  always_comb begin
    state_d = state_q;
    if (alarm) begin
      state_d = ALARM;
    end else begin
      case (state_q)
        ALARM:   if (alarm_clear) state_d = enable ? RUN : IDLE;
        RUN:     if (!enable)     state_d = IDLE;
        IDLE:    if (enable)      state_d = RUN;
        default:                  state_d = IDLE;
      endcase
    end
  end

  assign enter_run = (state_d == RUN) && (state_q != RUN);

  // Timebase runs in RUN and ALARM; it is not reset on entering ALARM so the
  // flash phase simply continues from wherever the heartbeat was.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == IDLE || enter_run || state_q == IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + COUNTER_WIDTH'(1);
    end
  end

  always_comb begin
    chase_d = chase_q;
    if (enter_run) begin
      chase_d = NUM_LEDS'(1);
    end else if (state_q == RUN && state_d == RUN && (&cnt_q[CHASE_BIT-1:0])) begin
      chase_d = {chase_q[NUM_LEDS-2:0], chase_q[NUM_LEDS-1]};
    end
  end

  always_comb begin
    stretch_d = stretch_q;
    if (activity) begin
      stretch_d = SW'(STRETCH_CYCLES);
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - SW'(1);
    end
  end

  assign key_d = key_loaded;

  // Outputs are decoded from next-state values and registered, so they change
  // on the same edge as the state they describe with no input-to-output path.
  always_comb begin
    led_d           = '0;
    gled_d          = 1'b0;
    alarm_latched_d = 1'b0;
    case (state_d)
      RUN: begin
        led_d  = chase_d;
        gled_d = key_d || (stretch_d != '0);
      end
      ALARM: begin
        led_d           = {NUM_LEDS{cnt_d[ALARM_BIT]}};
        alarm_latched_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      chase_q         <= NUM_LEDS'(1);
      stretch_q       <= '0;
      key_q           <= 1'b0;
      led_q           <= '0;
      gled_q          <= 1'b0;
      alarm_latched_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      chase_q         <= chase_d;
      stretch_q       <= stretch_d;
      key_q           <= key_d;
      led_q           <= led_d;
      gled_q          <= gled_d;
      alarm_latched_q <= alarm_latched_d;
    end
  end

  assign led           = led_q;
  assign gled          = gled_q;
  assign alarm_latched = alarm_latched_q;

endmodule

// File: tb/tb_rand_ice_status.sv
// Scoreboard bench for rand_ice_status: the driver queues hand-derived expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_rand_ice_status;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable = 1'b0, alarm = 1'b0, alarm_clear = 1'b0;
  logic       activity = 1'b0, key_loaded = 1'b0;
  logic [3:0] led;
  logic       gled, alarm_latched;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string      nm;
    logic [3:0] led;
    logic       gled;
    logic       al;
  } exp_t;

  exp_t exp_q[$];

  rand_ice_status #(
    .NUM_LEDS(4), .COUNTER_WIDTH(8), .CHASE_BIT(2), .ALARM_BIT(1), .STRETCH_CYCLES(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .alarm(alarm),
    .alarm_clear(alarm_clear), .activity(activity), .key_loaded(key_loaded),
    .led(led), .gled(gled), .alarm_latched(alarm_latched)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.nm, "led", 32'(led), 32'(e.led));
      chk(e.nm, "gled", 32'(gled), 32'(e.gled));
      chk(e.nm, "alarm_latched", 32'(alarm_latched), 32'(e.al));
    end
  end

  task automatic step(input logic en, input logic al, input logic clr, input logic act,
                      input logic key, input logic [3:0] eled, input logic egled,
                      input logic eal, input string nm);
    exp_t e;
    enable = en; alarm = al; alarm_clear = clr; activity = act; key_loaded = key;
    @(posedge clk);
    #1;
    e.nm = nm; e.led = eled; e.gled = egled; e.al = eal;
    exp_q.push_back(e);
  endtask

  function automatic logic [3:0] chase(input int i);
    return 4'(1 << ((i / 4) % 4));
  endfunction

  function automatic logic [3:0] flash(input int c);
    logic [7:0] v;
    v = 8'(c);
    return {4{v[1]}};
  endfunction

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("reset", "led", 32'(led), 32'h0);
    chk("reset", "gled", 32'(gled), 32'h0);
    chk("reset", "alarm_latched", 32'(alarm_latched), 32'h0);
    #19 reset_n = 1'b1;

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 4'h0, 0, 0, "idle");

    // Chase through several full rotations and past the 256-cycle counter wrap.
    for (int i = 0; i < 300; i++) step(1, 0, 0, 0, 0, chase(i), 0, 0, "chase");
    step(0, 0, 0, 0, 0, 4'h0, 0, 0, "to_idle");

    // Activity stretch, overlapping retrigger, key_loaded, then alarm entry.
    for (int i = 0; i < 24; i++) begin
      logic act, key, eg;
      act = (i == 1) || (i == 10) || (i == 12);
      key = (i == 20) || (i == 21);
      eg  = (i >= 1 && i <= 4) || (i >= 10 && i <= 15) || (i == 20) || (i == 21);
      step(1, 0, 0, act, key, chase(i), eg, 0, "stretch");
    end
    for (int i = 24; i < 42; i++) begin
      logic en, al, clr;
      en  = !(i >= 36);
      al  = (i == 24) || (i == 40);
      clr = (i == 40);
      step(en, al, clr, 0, 0, flash(i), 0, 1, "alarm");
    end
    step(1, 0, 1, 0, 0, 4'h1, 0, 0, "clear_run");
    for (int k = 1; k < 6; k++) step(1, 0, 0, 0, 0, chase(k), 0, 0, "rerun");
    step(1, 1, 0, 0, 0, flash(6), 0, 1, "alarm2");
    step(1, 0, 0, 0, 0, flash(7), 0, 1, "alarm2");
    step(0, 0, 1, 0, 0, 4'h0, 0, 0, "clear_idle");
    step(0, 0, 0, 0, 0, 4'h0, 0, 0, "clear_idle");

    // Asynchronous reset mid-chase with gled lit.
    for (int m = 0; m < 10; m++) step(1, 0, 0, (m == 8), 0, chase(m), (m >= 8), 0, "pre_reset");
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset", "led", 32'(led), 32'h0);
    chk("async_reset", "gled", 32'(gled), 32'h0);
    chk("async_reset", "alarm_latched", 32'(alarm_latched), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    for (int m = 0; m < 5; m++) step(1, 0, 0, 0, 0, chase(m), 0, 0, "post_reset");

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rand_ice_status.md
# rand_ice_status

Parametrised LED status controller for the iCEstick random number generator top level. It replaces the fixed free-running blink counter with three behaviours: a heartbeat chaser on the red LEDs, a latched alarm flash, and a green LED that shows key-loaded or pulse-stretched entropy activity. It sits between the entropy core status signals and the board LED pins.

## Interface
- NUM_LEDS, 4: number of red LEDs in the chaser; must be ≥ 2.
- COUNTER_WIDTH, 22: width of the free-running timebase counter.
- CHASE_BIT, 19: chaser advance period is 2^CHASE_BIT cycles; 1 ≤ CHASE_BIT < COUNTER_WIDTH.
- ALARM_BIT, 17: counter bit that drives the alarm flash; ALARM_BIT < COUNTER_WIDTH.
- STRETCH_CYCLES, 16: number of cycles gled stays on after an activity pulse; must be ≥ 1. The stretch counter is $clog2(STRETCH_CYCLES+1) bits wide.
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; run the heartbeat when high.
- alarm  in  1  level; alarm condition from the entropy core.
- alarm_clear  in  1  one-cycle pulse; acknowledges a latched alarm.
- activity  in  1  one-cycle pulse; entropy word delivered (valid && ack).
- key_loaded  in  1  level; key/seed loaded.
- led  out  NUM_LEDS  red LED drive.
- gled  out  1  green LED drive.
- alarm_latched  out  1  high while the FSM is in ALARM.

## Operation
- FSM states: IDLE, RUN, ALARM. Reset puts the FSM in IDLE.
- Transitions are evaluated every clk edge, in priority order:
  - alarm=1 in any state → ALARM.
  - In ALARM: alarm_clear=1 with alarm=0 → RUN if enable=1, otherwise IDLE. Anything else stays in ALARM.
  - In RUN: enable=0 → IDLE.
  - In IDLE: enable=1 → RUN.
- ALARM is sticky. Only reset, or alarm_clear while alarm is low, leaves it. enable=0 does not leave ALARM.
- Counter:
  - Holds 0 in IDLE.
  - Increments by 1 every cycle in RUN and ALARM, wrapping modulo 2^COUNTER_WIDTH.
  - Is loaded to 0 on the edge that enters RUN from IDLE or from ALARM.
  - Is not cleared on entry to ALARM.
- Chaser register (NUM_LEDS bits, one-hot):
  - Is set to 1 (bit 0) on every edge that enters RUN.
  - In RUN, rotates left by one (MSB wraps to bit 0) on each edge where counter[CHASE_BIT-1:0] is all ones.
  - Holds in other states.
- led output by state:
  - IDLE: all 0.
  - RUN: the chaser register.
  - ALARM: all bits equal counter[ALARM_BIT].
- Stretch counter:
  - An activity pulse loads STRETCH_CYCLES. This reload applies in every state, including a reload while the counter is already running.
  - Otherwise it decrements toward 0 and saturates at 0.
- gled output by state:
  - IDLE and ALARM: 0.
  - RUN: key_loaded_reg OR (stretch counter ≠ 0).
  - key_loaded is registered once before use.
- alarm_latched = (state == ALARM).
- All outputs are decoded from registers only; there is no combinational path from any input to any output.

## Timing
- Reset values: state IDLE, counter 0, chaser 1, stretch 0, key_loaded_reg 0. Outputs led=0, gled=0, alarm_latched=0.
- enable sampled high at edge N: from edge N, state=RUN, led=1, counter=0.
- With CHASE_BIT=c, each chaser position lasts exactly 2^c cycles.
- alarm sampled at edge N: from edge N, alarm_latched=1. The led flash follows counter[ALARM_BIT] with period 2^(ALARM_BIT+1) cycles.
- Simultaneous alarm and alarm_clear: alarm wins; the FSM stays in ALARM.
- Activity at edge N: stretch=STRETCH_CYCLES after edge N. In RUN, gled is high for exactly STRETCH_CYCLES cycles (edges N .. N+STRETCH_CYCLES-1), then low.
- key_loaded: one cycle of latency to gled.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronously), regardless of state.

## Test plan
Bench parameters: NUM_LEDS=4, COUNTER_WIDTH=8, CHASE_BIT=2, ALARM_BIT=1, STRETCH_CYCLES=4.
- Reset, then enable=1 → led=0001 for 4 cycles, then 0010, 0100, 1000, then 0001 again; check wrap after 16 cycles. Check COUNTER_WIDTH wrap after 256 cycles with no glitch.
- In RUN, a one-cycle activity pulse with key_loaded=0 → gled high for exactly 4 cycles. A second pulse 2 cycles later extends gled to 6 cycles total.
- In RUN, pulse alarm for 1 cycle → alarm_latched=1, gled=0, and all led toggle together every 2 cycles. Hold enable=0 → remains in ALARM.
- In ALARM, assert alarm_clear with alarm=1 → stays in ALARM. Then alarm_clear with alarm=0 and enable=1 → RUN with led=0001 and counter=0. Repeat with enable=0 → IDLE with led=0.
- Assert reset_n low mid-chase (led=0100, gled high) → led=0, gled=0, alarm_latched=0 before the next clock edge. After release, enable=1 → chaser restarts at 0001.
